riscv_test_monitor: RTL
=======================

Name: riscv_test_monitor

Overview:
Synthesizable pass/fail monitor for riscv-tests style self-checking programs on the riscv_core. It snoops the regfile write port and shadows a done register, a pass register and a test-number register. After a done write it waits a settle window, then latches PASS or FAIL; it latches TIMEOUT if no done write arrives within a cycle budget. It is instantiated beside riscv_core in core-level benches and on the FPGA top, where its sticky flags drive LEDs or status registers.

Parameters:
XLEN, 32, data width of the regfile write port and shadow registers
DONE_REG, 26, regfile index whose write signals test completion
PASS_REG, 27, regfile index holding the pass flag
TNUM_REG, 3, regfile index holding the failing test number (gp)
DONE_VAL, 1, value written to DONE_REG that means done
PASS_VAL, 1, PASS_REG value that means pass
SETTLE_CYC, 2, cycles between the done write and the verdict; must be >= 1
TIMEOUT_CYC, 100000, run-cycle budget; 0 disables the timeout
CNT_W, 32, cycle counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
en_i  in  1  arm monitoring; core released from reset
rf_we_i  in  1  regfile write enable
rf_waddr_i  in  5  regfile write address
rf_wdata_i  in  XLEN  regfile write data
running_o  out  1  FSM in RUN or SETTLE
done_o  out  1  sticky; a verdict has been reached
pass_o  out  1  sticky pass
fail_o  out  1  sticky fail
timeout_o  out  1  sticky timeout
fail_tnum_o  out  XLEN  TNUM shadow captured at the FAIL verdict
cycle_cnt_o  out  CNT_W  cycles spent in RUN+SETTLE

Behaviour:
- Reset: all outputs 0, shadows 0, counters 0, FSM IDLE. Reset mid-test aborts and clears everything, including sticky flags.
- Shadows: on rf_we_i=1 with addr equal to PASS_REG or TNUM_REG, the shadow loads wdata at the next edge. Writes to address 0 are ignored. Shadows update in every state.
- FSM states: IDLE, RUN, SETTLE, PASS, FAIL, TMO.
- IDLE -> RUN when en_i=1. en_i is sampled only in IDLE; dropping it later has no effect.
- RUN -> SETTLE on rf_we_i=1, addr=DONE_REG, wdata=DONE_VAL. A done write in cycle N gives SETTLE from N+1. A DONE_REG write with any other value is ignored.
- RUN -> TMO when TIMEOUT_CYC!=0 and cycle_cnt_o reaches TIMEOUT_CYC-1 with no done write that cycle. If the done write and the timeout boundary coincide, the done write wins.
- SETTLE: a down-counter loaded with SETTLE_CYC-1 runs to 0. Further done writes are ignored. There is no timeout in SETTLE.
- SETTLE exit: at the counter-0 cycle the registered PASS shadow is compared with PASS_VAL. Equal -> PASS, else FAIL. A write landing in that same cycle is not seen.
- Verdict timing: outputs assert in cycle N+1+SETTLE_CYC. done_o goes high with exactly one of pass_o, fail_o or timeout_o. On FAIL, fail_tnum_o captures the TNUM shadow.
- PASS, FAIL and TMO are terminal; only rst leaves them.
- cycle_cnt_o increments each cycle in RUN and SETTLE, saturates at all-ones, and freezes in terminal states.
- running_o = (state==RUN || state==SETTLE).

Decomposition:
- Shared package riscv_mon_pkg: FSM state encoding, default register indices (26/27/3), DONE_VAL and PASS_VAL defaults.
- One sub-module, mon_shadow_reg: write-port-snooping shadow register parameterised by index and XLEN, instantiated twice (PASS and TNUM).

Test Plan:
- Pass: en_i=1, write x27=1 at cycle 5, x26=1 at cycle 10 -> pass_o=done_o=1 at cycle 13 (SETTLE_CYC=2), fail_o=timeout_o=0, cycle_cnt_o frozen.
- Fail: write x3=0x0000000B, x27=0, then x26=1 -> fail_o=1, fail_tnum_o=0x0B, pass_o=0.
- Late pass write: x26=1 at N, x27=1 written in the final SETTLE cycle (N+2) -> FAIL, proving the registered compare.
- Timeout: TIMEOUT_CYC=50, no done write -> timeout_o=1 on entering the 51st run cycle. Timeout at the boundary with a coincident done write -> SETTLE, no timeout.
- Ignored writes: x26=5, x0 writes, and a second x26=1 during SETTLE -> no verdict change and settle timing unchanged.
- Reset mid-SETTLE: rst=1 for 1 cycle -> all outputs 0, FSM IDLE. Re-arm and pass again with the correct latency.

Source files
------------

// File: rtl/riscv_mon_pkg.sv
// Shared definitions for the riscv-tests pass/fail monitor: FSM state
// encoding, default register indices and the magic values the test
// programs write to signal completion and success.
package riscv_mon_pkg;

  // Monitor FSM states. PASS, FAIL and TMO are terminal until reset.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_PASS   = 3'd3,
    ST_FAIL   = 3'd4,
    ST_TMO    = 3'd5
  } mon_state_e;

  // riscv-tests convention: x26 flags completion, x27 holds the pass flag,
  // gp (x3) holds the number of the failing test.
  localparam int DEF_DONE_REG = 26;
  localparam int DEF_PASS_REG = 27;
  localparam int DEF_TNUM_REG = 3;

  // Values that mean "done" and "passed".
  localparam int DEF_DONE_VAL = 1;
  localparam int DEF_PASS_VAL = 1;

  // True once a verdict has been latched.
  function automatic logic is_terminal(input mon_state_e s);
    return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TMO);
  endfunction

endpackage

// File: rtl/mon_shadow_reg.sv
// Shadow copy of a single architectural register, built by snooping the
// regfile write port. Writes to x0 never land, matching the core.
module mon_shadow_reg
  import riscv_mon_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int IDX  = DEF_PASS_REG
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rf_we,
  input  logic [4:0]      rf_waddr,
  input  logic [XLEN-1:0] rf_wdata,
  output logic [XLEN-1:0] value
);

  localparam logic [4:0] ADDR = 5'(IDX);

  logic hit;

  assign hit = rf_we && (rf_waddr == ADDR) && (rf_waddr != 5'd0);

  // Capture the written value whenever the core writes our register.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (hit) begin
      value <= rf_wdata;
    end
  end

endmodule

// File: rtl/riscv_test_monitor.sv
// Pass/fail monitor for self-checking riscv-tests programs. Watches the
// regfile write port for the completion write, waits a settle window so
// the pass flag has certainly been written, then latches a sticky verdict.
// A run-cycle budget catches programs that never finish.
module riscv_test_monitor
  import riscv_mon_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DONE_REG    = DEF_DONE_REG,
  parameter int PASS_REG    = DEF_PASS_REG,
  parameter int TNUM_REG    = DEF_TNUM_REG,
  parameter int DONE_VAL    = DEF_DONE_VAL,
  parameter int PASS_VAL    = DEF_PASS_VAL,
  parameter int SETTLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 100000,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             rf_we_i,
  input  logic [4:0]       rf_waddr_i,
  input  logic [XLEN-1:0]  rf_wdata_i,
  output logic             running_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             timeout_o,
  output logic [XLEN-1:0]  fail_tnum_o,
  output logic [CNT_W-1:0] cycle_cnt_o
);

  // Settle counter only needs to hold SETTLE_CYC-1.
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC - 1);

  localparam logic [4:0]      DONE_ADDR = 5'(DONE_REG);
  localparam logic [XLEN-1:0] DONE_DATA = XLEN'(DONE_VAL);
  localparam logic [XLEN-1:0] PASS_DATA = XLEN'(PASS_VAL);

  // A zero budget disables the timeout entirely.
  localparam bit              TMO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

  mon_state_e      state;
  mon_state_e      state_next;
  logic [SW-1:0]   settle_cnt;
  logic [CNT_W-1:0] cycle_cnt;
  logic [XLEN-1:0] pass_shadow;
  logic [XLEN-1:0] tnum_shadow;
  logic            done_hit;
  logic            tmo_hit;
  logic            running;

  mon_shadow_reg #(
    .XLEN (XLEN),
    .IDX  (PASS_REG)
  ) u_pass_shadow (
    .clk      (clk),
    .rst      (rst),
    .rf_we    (rf_we_i),
    .rf_waddr (rf_waddr_i),
    .rf_wdata (rf_wdata_i),
    .value    (pass_shadow)
  );

  mon_shadow_reg #(
    .XLEN (XLEN),
    .IDX  (TNUM_REG)
  ) u_tnum_shadow (
    .clk      (clk),
    .rst      (rst),
    .rf_we    (rf_we_i),
    .rf_waddr (rf_waddr_i),
    .rf_wdata (rf_wdata_i),
    .value    (tnum_shadow)
  );

  assign done_hit = rf_we_i && (rf_waddr_i == DONE_ADDR) &&
                    (rf_waddr_i != 5'd0) && (rf_wdata_i == DONE_DATA);
  assign tmo_hit  = TMO_EN && (cycle_cnt == TMO_LAST);
  assign running  = (state == ST_RUN) || (state == ST_SETTLE);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a done write beats a coincident timeout, and the
  // settle exit looks only at the already-registered pass shadow.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (en_i) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (done_hit) begin
          state_next = ST_SETTLE;
        end else if (tmo_hit) begin
          state_next = ST_TMO;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == '0) begin
          state_next = (pass_shadow == PASS_DATA) ? ST_PASS : ST_FAIL;
        end
      end
      ST_PASS, ST_FAIL, ST_TMO: begin
        state_next = state;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Settle down-counter: held at its load value while running so it is
  // primed on entry to SETTLE, then counts down to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
    end else if (state == ST_RUN) begin
      settle_cnt <= SETTLE_LOAD;
    end else if ((state == ST_SETTLE) && (settle_cnt != '0)) begin
      settle_cnt <= settle_cnt - SW'(1);
    end
  end

  // Run-cycle counter: saturating, frozen once a verdict is reached.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (running && (cycle_cnt != '1)) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

  // Capture the failing test number at the moment the FAIL verdict lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_tnum_o <= '0;
    end else if ((state == ST_SETTLE) && (state_next == ST_FAIL)) begin
      fail_tnum_o <= tnum_shadow;
    end
  end

  assign running_o   = running;
  assign done_o      = is_terminal(state);
  assign pass_o      = (state == ST_PASS);
  assign fail_o      = (state == ST_FAIL);
  assign timeout_o   = (state == ST_TMO);
  assign cycle_cnt_o = cycle_cnt;

endmodule
